// File: rtl/uart_rx_pkg.sv
// Shared UART constants: standard baud divisors and the receiver FSM encoding.
// The transmitter imports this same package.
package uart_rx_pkg;

  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B9600   = 1250;

  localparam int BAUD_W     = 16;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    LOAD = 2'd2,
    DAV  = 2'd3
  } rx_state_e;

  // Offset of the first sample from the start edge: half a bit period.
  function automatic logic [BAUD_W-1:0] half_period(input int baud);
    return BAUD_W'(baud / 2);
  endfunction

endpackage

// File: rtl/baudgen_rx.sv
// Receive baud tick generator. The counter stays at 0 while disabled.
// Once enabled it ticks BAUD/2 cycles later, and then every BAUD cycles.
module baudgen_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_ena,
  output logic clk_out
);

  localparam logic [BAUD_W-1:0] TC   = BAUD_W'(BAUD - 1);
  localparam logic [BAUD_W-1:0] MID  = half_period(BAUD) - 16'd1;
  localparam logic [BAUD_W-1:0] STEP = 16'd1;

  logic [BAUD_W-1:0] cnt;

  // Wraps every BAUD cycles. The tick sits at the half-period point of each
  // wrap, so the first tick lands mid start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!clk_ena) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + STEP;
    end
  end

  assign clk_out = clk_ena && (cnt == MID);

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver. The optional framing-error output is enabled with UART_RX_FERR_EN.
// States: IDLE wait for start edge | RECV sample 10 bits | LOAD latch byte | DAV pulse rcv
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rcv,
  output logic [7:0] data,
  output logic       busy
`ifdef UART_RX_FERR_EN
  ,
  output logic       ferr
`endif
);

  rx_state_e             state, state_next;
  logic                  rx_meta, rx_s, rx_prev;
  logic                  start_edge;
  logic                  baud_ena, tick;
  logic [FRAME_BITS-1:0] shifter;
  logic [3:0]            bitc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;
  assign baud_ena   = (state == RECV);

  baudgen_rx #(.BAUD(BAUD)) u_baudgen (
    .clk     (clk),
    .rst     (rst),
    .clk_ena (baud_ena),
    .clk_out (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_edge) state_next = RECV;
      // shifter[9] holds the bit just sampled; a high start bit is a glitch.
      RECV: begin
        if (bitc == 4'd1 && shifter[9]) begin
          state_next = IDLE;
        end else if (bitc == 4'd10) begin
          state_next = shifter[0] ? IDLE : LOAD;
        end
      end
      LOAD:    state_next = DAV;
      DAV:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifter <= '1;
      bitc    <= '0;
      data    <= 8'h00;
      rcv     <= 1'b0;
    end else begin
      rcv <= (state_next == DAV);
      if (state == IDLE) begin
        bitc <= '0;
      end else if (tick) begin
        shifter <= {rx_s, shifter[FRAME_BITS-1:1]};
        bitc    <= bitc + 4'd1;
      end
      if (state == LOAD) begin
        data <= shifter[8:1];
      end
    end
  end

`ifdef UART_RX_FERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr <= 1'b0;
    end else begin
      ferr <= (state_next == DAV) && !shifter[9];
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule
